// File: rtl/utils.sv
// ---------------------------------------------------------------------------
// utils: shared package for the integer back end.
//   INT_IQ_DEPTH / INT_IQ_TAG_W : default queue depth and rename-tag width
//   tagged_operand_t            : {pending, tag}; pending=1 -> operand waits
//                                 on that tag to appear on the CDB
//   int_fifo_data               : dispatch packet carried to the int unit
//   iq_wake()                   : applies one CDB broadcast to a packet
// ---------------------------------------------------------------------------
package utils;

    localparam int INT_IQ_DEPTH = 4;
    localparam int INT_IQ_TAG_W = 6;

    typedef struct packed {
        logic                    pending;
        logic [INT_IQ_TAG_W-1:0] tag;
    } tagged_operand_t;

    typedef struct packed {
        logic [3:0]              alu_op;
        logic [INT_IQ_TAG_W-1:0] rd_tag;
        tagged_operand_t         rs1_tag;
        logic [31:0]             rs1_data;
        tagged_operand_t         rs2_tag;
        logic [31:0]             rs2_data;
    } int_fifo_data;

    // Capture a CDB result into any operand still waiting on its tag.
    // rs1 and rs2 are handled independently so both can resolve at once.
    function automatic int_fifo_data iq_wake(
        input int_fifo_data            pkt,
        input logic                    cdb_valid,
        input logic [INT_IQ_TAG_W-1:0] cdb_tag,
        input logic [31:0]             cdb_data
    );
        int_fifo_data r;
        r = pkt;
        if (cdb_valid && pkt.rs1_tag.pending && (pkt.rs1_tag.tag == cdb_tag)) begin
            r.rs1_tag.pending = 1'b0;
            r.rs1_data        = cdb_data;
        end
        if (cdb_valid && pkt.rs2_tag.pending && (pkt.rs2_tag.tag == cdb_tag)) begin
            r.rs2_tag.pending = 1'b0;
            r.rs2_data        = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// ---------------------------------------------------------------------------
// int_issue_queue_if: bundle of dispatch, CDB, flush and issue signals for
// the integer issue queue.
//   master : dispatcher / CDB / execution-unit side (drives i_* and cdb_*)
//   slave  : the issue queue itself (drives o_*)
// ---------------------------------------------------------------------------
interface int_issue_queue_if
    import utils::*;
#(
    parameter int TAG_W = INT_IQ_TAG_W
) ();

    int_fifo_data     i_dispatch_data;
    logic             i_dispatch_en;
    logic             o_queue_full;
    logic             o_queue_empty;
    logic [TAG_W-1:0] cdb_tag;
    logic             cdb_valid;
    logic [31:0]      cdb_data;
    logic             i_flush;
    int_fifo_data     o_issue_data;
    logic             o_issue_valid;
    logic             i_issue_ready;

    modport master (
        output i_dispatch_data, i_dispatch_en, cdb_tag, cdb_valid, cdb_data,
               i_flush, i_issue_ready,
        input  o_queue_full, o_queue_empty, o_issue_data, o_issue_valid
    );

    modport slave (
        input  i_dispatch_data, i_dispatch_en, cdb_tag, cdb_valid, cdb_data,
               i_flush, i_issue_ready,
        output o_queue_full, o_queue_empty, o_issue_data, o_issue_valid
    );

endinterface

// File: rtl/int_issue_queue_select.sv
// ---------------------------------------------------------------------------
// iq_select: combinational pick of one ready entry for issue queues.
//   ready     in  DEPTH        : per-entry ready flags
//   age       in  DEPTH x DEPTH: (INT_IQ_AGE_SELECT_EN only) age[i][j]=1 when
//                                entry i is younger than entry j
//   grant     out DEPTH        : one-hot selected entry (0 when none ready)
//   any_ready out 1            : at least one entry ready
// Macro INT_IQ_AGE_SELECT_EN: oldest-ready pick; otherwise lowest index.
// ---------------------------------------------------------------------------
module iq_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef INT_IQ_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic                        any_ready
);

    assign any_ready = |ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_grant
`ifdef INT_IQ_AGE_SELECT_EN
            // Oldest: no other ready entry is older than this one.
            assign grant[gi] = ready[gi] & ~|(ready & age[gi]);
`else
            if (gi == 0) begin : g_first
                assign grant[gi] = ready[gi];
            end else begin : g_rest
                assign grant[gi] = ready[gi] & ~|ready[gi-1:0];
            end
`endif
        end
    endgenerate

endmodule

// File: rtl/int_issue_queue.sv
// ---------------------------------------------------------------------------
// int_issue_queue: DEPTH-entry integer issue queue between the dispatcher
// and the integer execution unit. Snoops the CDB to wake pending operands
// and offers one fully-resolved instruction per cycle (valid/ready).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   iq (slave)     : dispatch packet/strobe, full/empty, CDB, flush,
//                    issue data/valid/ready
// Macro INT_IQ_AGE_SELECT_EN: keep an age matrix and issue oldest-ready
// first; without it the lowest-index ready entry is issued.
// ---------------------------------------------------------------------------
module int_issue_queue
    import utils::*;
#(
    parameter int DEPTH = INT_IQ_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    int_issue_queue_if.slave iq
);

    localparam int DW = $bits(int_fifo_data);

    logic [DEPTH-1:0] valid_q, valid_d;
    int_fifo_data     entry_q [DEPTH];
    int_fifo_data     entry_d [DEPTH];
    // Remembers an offer that was not accepted so it stays put until taken.
    logic             held_q, held_d;
    logic [DEPTH-1:0] held_grant_q, held_grant_d;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] sel_grant;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] alloc_oh;
    logic             sel_any;
    logic             issue_valid;
    logic             issue_fire;
    logic             alloc_fire;
    logic             full;
    logic [DW-1:0]    issue_bits;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ready
            assign ready_vec[gi] = valid_q[gi]
                                 & ~entry_q[gi].rs1_tag.pending
                                 & ~entry_q[gi].rs2_tag.pending;
        end
    endgenerate

`ifdef INT_IQ_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

    iq_select #(.DEPTH(DEPTH)) u_select (
        .ready     (ready_vec),
        .age       (age_q),
        .grant     (sel_grant),
        .any_ready (sel_any)
    );
`else
    iq_select #(.DEPTH(DEPTH)) u_select (
        .ready     (ready_vec),
        .grant     (sel_grant),
        .any_ready (sel_any)
    );
`endif

    assign grant       = held_q ? held_grant_q : sel_grant;
    assign issue_valid = held_q | sel_any;
    assign issue_fire  = issue_valid & iq.i_issue_ready;

    always_comb begin
        issue_bits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_bits = issue_bits | entry_q[i];
            end
        end
    end

    assign iq.o_issue_valid = issue_valid;
    assign iq.o_issue_data  = issue_valid ? int_fifo_data'(issue_bits) : '0;
    assign full             = &valid_q;
    assign iq.o_queue_full  = full;
    assign iq.o_queue_empty = ~|valid_q;

    // Lowest free slot from the registered valid bits: a slot freed by an
    // issue this cycle is only reusable next cycle.
    always_comb begin
        logic found;
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign alloc_fire = iq.i_dispatch_en & ~full & ~iq.i_flush;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (valid_q[i]) begin
                entry_d[i] = iq_wake(entry_q[i], iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
            end
        end
        if (issue_fire) begin
            valid_d = valid_d & ~grant;
        end
        if (alloc_fire) begin
            valid_d = valid_d | alloc_oh;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    entry_d[i] = iq_wake(iq.i_dispatch_data, iq.cdb_valid,
                                         iq.cdb_tag, iq.cdb_data);
                end
            end
        end
        if (iq.i_flush) begin
            valid_d = '0;
        end

        held_d       = issue_valid & ~iq.i_issue_ready & ~iq.i_flush;
        held_grant_d = held_d ? grant : '0;
    end

`ifdef INT_IQ_AGE_SELECT_EN
    // New entry is younger than everything valid at the start of the cycle;
    // rows and columns of entries that end the cycle invalid are cleared.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire && alloc_oh[i]) begin
                age_d[i] = valid_q;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (!valid_d[j]) begin
                age_d[j] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    age_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= '0;
            held_q       <= 1'b0;
            held_grant_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            held_q       <= held_d;
            held_grant_q <= held_grant_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_int_issue_queue: table-driven directed test of int_issue_queue.
// Each table row is one clock cycle: inputs applied at the falling edge and
// the registered-state outputs compared at the same point.
// ---------------------------------------------------------------------------
module tb_int_issue_queue;
    import utils::*;

`ifdef INT_IQ_AGE_SELECT_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int_issue_queue_if #(.TAG_W(INT_IQ_TAG_W)) iq_if ();

    int_issue_queue #(.DEPTH(INT_IQ_DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .iq      (iq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         flush;
        logic         en;
        int_fifo_data d;
        logic         cv;
        logic [5:0]   ct;
        logic [31:0]  cd;
        logic         rdy;
        logic         e_full;
        logic         e_empty;
        logic         e_valid;
        int_fifo_data e_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int_fifo_data mk(input logic [3:0] op, input logic [5:0] rd,
                                        input logic p1, input logic [5:0] t1, input logic [31:0] d1,
                                        input logic p2, input logic [5:0] t2, input logic [31:0] d2);
        int_fifo_data r;
        r.alu_op          = op;
        r.rd_tag          = rd;
        r.rs1_tag.pending = p1;
        r.rs1_tag.tag     = t1;
        r.rs1_data        = d1;
        r.rs2_tag.pending = p2;
        r.rs2_tag.tag     = t2;
        r.rs2_data        = d2;
        return r;
    endfunction

    task automatic add(input logic fl, input logic en, input int_fifo_data d,
                       input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                       input logic rdy, input logic ef, input logic ee, input logic ev,
                       input int_fifo_data ed);
        vec_t v;
        v.flush = fl; v.en = en; v.d = d; v.cv = cv; v.ct = ct; v.cd = cd; v.rdy = rdy;
        v.e_full = ef; v.e_empty = ee; v.e_valid = ev; v.e_data = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic en, input int_fifo_data d,
                         input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                         input logic rdy);
        iq_if.i_flush         = fl;
        iq_if.i_dispatch_en   = en;
        iq_if.i_dispatch_data = d;
        iq_if.cdb_valid       = cv;
        iq_if.cdb_tag         = ct;
        iq_if.cdb_data        = cd;
        iq_if.i_issue_ready   = rdy;
    endtask

    task automatic chk_out(input int idx, input logic ef, input logic ee, input logic ev,
                           input int_fifo_data ed);
        chk("full",  idx, 128'(iq_if.o_queue_full),  128'(ef));
        chk("empty", idx, 128'(iq_if.o_queue_empty), 128'(ee));
        chk("valid", idx, 128'(iq_if.o_issue_valid), 128'(ev));
        chk("data",  idx, 128'(iq_if.o_issue_data),  128'(ed));
    endtask

    initial begin
        int_fifo_data z, a, b, br, x, c, cr, p2r, f1r, f0r, f2r, f3r, g, gr, h, l;
        int_fifo_data p [5];
        int_fifo_data f [4];

        z   = '0;
        a   = mk(4'd1, 6'd1, 1'b0, 6'd0, 32'h11, 1'b0, 6'd0, 32'h22);
        b   = mk(4'd2, 6'd2, 1'b1, 6'd5, 32'h0, 1'b0, 6'd0, 32'h33);
        br  = mk(4'd2, 6'd2, 1'b0, 6'd5, 32'h1234, 1'b0, 6'd0, 32'h33);
        for (int k = 0; k < 5; k++) begin
            p[k] = mk(4'd4, 6'(k), 1'b1, 6'(10 + k), 32'h0, 1'b0, 6'd0, 32'h100 + 32'(k));
        end
        p2r = mk(4'd4, 6'd2, 1'b0, 6'd12, 32'hAAAA, 1'b0, 6'd0, 32'h102);
        x   = mk(4'd5, 6'd7, 1'b0, 6'd0, 32'h1, 1'b0, 6'd0, 32'h2);
        c   = mk(4'd3, 6'd3, 1'b0, 6'd0, 32'h44, 1'b1, 6'd9, 32'h0);
        cr  = mk(4'd3, 6'd3, 1'b0, 6'd0, 32'h44, 1'b0, 6'd9, 32'hBEEF);
        for (int k = 0; k < 4; k++) begin
            f[k] = mk(4'd6, 6'(k), 1'b1, 6'(20 + k), 32'h0, 1'b0, 6'd0, 32'h200 + 32'(k));
        end
        f0r = mk(4'd6, 6'd0, 1'b0, 6'd20, 32'h2020, 1'b0, 6'd0, 32'h200);
        f1r = mk(4'd6, 6'd1, 1'b0, 6'd21, 32'h2121, 1'b0, 6'd0, 32'h201);
        f2r = mk(4'd6, 6'd2, 1'b0, 6'd22, 32'h2222, 1'b0, 6'd0, 32'h202);
        f3r = mk(4'd6, 6'd3, 1'b0, 6'd23, 32'h2323, 1'b0, 6'd0, 32'h203);
        g   = mk(4'd7, 6'd8, 1'b1, 6'd23, 32'h0, 1'b0, 6'd0, 32'h300);
        gr  = mk(4'd7, 6'd8, 1'b0, 6'd23, 32'h2323, 1'b0, 6'd0, 32'h300);
        // Entry 3 (F3) is older than entry 1 (G) when both become ready.
        h   = AGE ? f3r : gr;
        l   = AGE ? gr  : f3r;

        //   fl  en  pkt   cv  ct  cd         rdy  full empty valid data
        add(0, 1, a,    0, 0,  0,         1,   0, 1, 0, z);   // 0  dispatch A
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 1, a);   // 1  A offered
        add(0, 0, z,    0, 0,  0,         1,   0, 1, 0, z);   // 2  empty again
        add(0, 1, b,    0, 0,  0,         1,   0, 1, 0, z);   // 3  dispatch B (rs1 tag5)
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 0, z);   // 4  waiting
        add(0, 0, z,    1, 5,  32'h1234,  1,   0, 0, 0, z);   // 5  CDB tag5
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 1, br);  // 6  B issues
        add(0, 0, z,    0, 0,  0,         1,   0, 1, 0, z);   // 7
        add(0, 1, p[0], 0, 0,  0,         1,   0, 1, 0, z);   // 8  fill
        add(0, 1, p[1], 0, 0,  0,         1,   0, 0, 0, z);   // 9
        add(0, 1, p[2], 0, 0,  0,         1,   0, 0, 0, z);   // 10
        add(0, 1, p[3], 0, 0,  0,         1,   0, 0, 0, z);   // 11
        add(0, 1, p[4], 0, 0,  0,         1,   1, 0, 0, z);   // 12 fifth dropped
        add(0, 0, z,    1, 12, 32'hAAAA,  1,   1, 0, 0, z);   // 13 wake entry 2
        add(0, 0, z,    0, 0,  0,         1,   1, 0, 1, p2r); // 14 entry 2 issues
        add(1, 1, x,    0, 0,  0,         1,   0, 0, 0, z);   // 15 flush + dispatch
        add(0, 0, z,    0, 0,  0,         1,   0, 1, 0, z);   // 16 empty, X not written
        add(0, 1, c,    1, 9,  32'hBEEF,  1,   0, 1, 0, z);   // 17 C with same-cycle CDB
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 1, cr);  // 18 C issues
        add(0, 1, f[0], 0, 0,  0,         0,   0, 1, 0, z);   // 19
        add(0, 1, f[1], 0, 0,  0,         0,   0, 0, 0, z);   // 20
        add(0, 1, f[2], 0, 0,  0,         0,   0, 0, 0, z);   // 21
        add(0, 1, f[3], 0, 0,  0,         0,   0, 0, 0, z);   // 22
        add(0, 0, z,    1, 21, 32'h2121,  0,   1, 0, 0, z);   // 23 wake entry 1
        add(0, 0, z,    0, 0,  0,         1,   1, 0, 1, f1r); // 24 entry 1 issues
        add(0, 1, g,    0, 0,  0,         0,   0, 0, 0, z);   // 25 G into entry 1
        add(0, 0, z,    1, 23, 32'h2323,  0,   1, 0, 0, z);   // 26 wake entries 1,3
        add(0, 0, z,    0, 0,  0,         0,   1, 0, 1, h);   // 27 held offer
        add(0, 0, z,    1, 20, 32'h2020,  0,   1, 0, 1, h);   // 28 wake entry 0
        add(0, 0, z,    0, 0,  0,         0,   1, 0, 1, h);   // 29 no preempt
        add(0, 0, z,    0, 0,  0,         0,   1, 0, 1, h);   // 30
        add(0, 0, z,    0, 0,  0,         0,   1, 0, 1, h);   // 31
        add(0, 0, z,    0, 0,  0,         1,   1, 0, 1, h);   // 32 accepted
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 1, f0r); // 33
        add(0, 0, z,    0, 0,  0,         1,   0, 0, 1, l);   // 34
        add(0, 0, z,    0, 0,  0,         0,   0, 0, 0, z);   // 35 only entry 2 left

        rst_n = 1'b0;
        drive(0, 0, z, 0, 0, 0, 0);
        #1;
        chk_out(-1, 1'b0, 1'b1, 1'b0, z);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].en, vecs[i].d, vecs[i].cv, vecs[i].ct,
                  vecs[i].cd, vecs[i].rdy);
            $display("vec %0d: en=%0b flush=%0b cdb=%0b/%0d rdy=%0b -> full=%0b empty=%0b valid=%0b data=%0h",
                     i, vecs[i].en, vecs[i].flush, vecs[i].cv, vecs[i].ct, vecs[i].rdy,
                     iq_if.o_queue_full, iq_if.o_queue_empty, iq_if.o_issue_valid,
                     iq_if.o_issue_data);
            chk_out(i, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_valid, vecs[i].e_data);
            @(negedge clk);
        end

        // Wake the last entry, then drop reset mid-cycle while it is offered.
        drive(0, 0, z, 1, 6'd22, 32'h2222, 0);
        @(negedge clk);
        drive(0, 0, z, 0, 0, 0, 0);
        chk("pre_rst_valid", 100, 128'(iq_if.o_issue_valid), 128'(1'b1));
        chk("pre_rst_data",  100, 128'(iq_if.o_issue_data),  128'(f2r));
        $display("mid-run reset: offer valid=%0b data=%0h", iq_if.o_issue_valid, iq_if.o_issue_data);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out(101, 1'b0, 1'b1, 1'b0, z);
        $display("after reset: full=%0b empty=%0b valid=%0b", iq_if.o_queue_full,
                 iq_if.o_queue_empty, iq_if.o_issue_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Integer issue queue that sits between the dispatcher and the integer execution unit, replacing the plain integer exec FIFO on the consumer side. It accepts one `int_fifo_data` packet per cycle from the dispatcher, holds up to `DEPTH` instructions, and snoops the CDB to capture operands still pending on a tag. Each cycle it offers one instruction with both operands ready to the integer unit over a valid/ready handshake.

## Interface
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `TAG_W`, 6: width of the rename tag, matching the tag FIFO.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_dispatch_data` in `$bits(int_fifo_data)`: dispatch packet. `rsN_tag` is {pending, tag}; pending=1 means the operand is waiting on that tag.
- `i_dispatch_en` in 1: write strobe for the dispatch packet.
- `o_queue_full` out 1: all entries are valid.
- `o_queue_empty` out 1: no entry is valid.
- `cdb_tag` in TAG_W: broadcast tag on the CDB.
- `cdb_valid` in 1: CDB broadcast is valid.
- `cdb_data` in 32: CDB result.
- `i_flush` in 1: synchronous clear of all entries.
- `o_issue_data` out `$bits(int_fifo_data)`: selected packet, with both pending bits 0 and both data fields resolved.
- `o_issue_valid` out 1: a ready entry is being offered.
- `i_issue_ready` in 1: the integer unit accepts this cycle.

## Operation
- Entry state per slot: a valid bit plus the stored packet. Entry valid bits and packet fields are reset to 0.
- Allocation:
  - On `i_dispatch_en && !o_queue_full && !i_flush`, the packet is written into the lowest-index free entry.
  - `i_dispatch_en` while full is dropped. The dispatcher must not assert it in that case.
- Dispatch-time snoop: if `cdb_valid` is set and an incoming pending operand's tag equals `cdb_tag`, the entry stores `cdb_data` with pending cleared.
- Wakeup:
  - Each cycle, for every valid entry and each operand with pending=1 and tag == `cdb_tag` while `cdb_valid` is set, load `cdb_data` and clear pending.
  - rs1 and rs2 update independently; both can match in the same cycle.
- Ready: an entry is ready when it is valid, rs1 pending=0 and rs2 pending=0.
- Select:
  - `o_issue_valid` = any entry ready.
  - `o_issue_data` is the selected entry. It is 0 when `o_issue_valid` is 0.
- Issue: on `o_issue_valid && i_issue_ready`, the selected entry's valid bit clears at the edge.
- Simultaneous events:
  - Issue and dispatch in the same cycle: both take effect. The dispatch uses the free-slot view registered at the start of the cycle, so a slot freed that cycle is not reused until the next cycle.
- Flush:
  - `i_flush` clears every valid bit at the next edge.
  - Flush takes priority over dispatch and issue; an issue handshake in the flush cycle still completes at the execution unit.
- Reset mid-operation clears all entries asynchronously. Outputs return to their reset values immediately.
- Reset values: `o_queue_full`=0, `o_queue_empty`=1, `o_issue_valid`=0, `o_issue_data`=0.

## Timing
- Dispatch to earliest issue: 1 cycle. The written entry can be offered the cycle after `i_dispatch_en`.
- CDB wakeup to earliest issue: 1 cycle after the broadcast cycle.
- `o_issue_valid` and `o_issue_data` are combinational from registered entry state only. There is no combinational path from `i_issue_ready`, the CDB or dispatch to these outputs.
- `o_queue_full` and `o_queue_empty` are combinational from the registered valid bits.
- Throughput: one dispatch and one issue per cycle.
- Handshake: while `o_issue_valid` is held and `i_issue_ready` is low, the offered entry stays selected. A newly ready entry does not preempt it.

## Configuration
- Macro `INT_IQ_AGE_SELECT_EN`.
- Defined:
  - A DEPTH×DEPTH age matrix is kept. It is set on allocation against all currently valid entries and cleared on free or flush.
  - Select picks the oldest ready entry.
- Undefined:
  - Select picks the lowest-index ready entry. No age state is built.
- Allocation policy, timing and the handshake are identical in both builds.

## Structure
- The shared package in `utils.sv` holds:
  - `int_fifo_data`, reused unchanged.
  - A new `tagged_operand_t` {pending, tag[TAG_W-1:0]}.
  - The constant `INT_IQ_DEPTH`.
- One sub-module, `iq_select`: a ready vector (plus age matrix when enabled) in, a one-hot grant and an any-ready flag out. It is purely combinational and reusable for the ld/st, mult and div queues.

## Test plan
- Reset, then dispatch packet A with rs1/rs2 pending=0 at cycle 0, `i_issue_ready`=1:
  - `o_issue_valid`=1 at cycle 1 with A's data.
  - `o_queue_empty`=1 at cycle 2.
- Dispatch B with rs1 = {1, tag 5}:
  - No issue while waiting.
  - CDB {valid, tag 5, data 0x1234} at cycle 3 → issue at cycle 4 with rs1_data=0x1234 and pending=0.
- Fill 4 entries, all pending, then dispatch a fifth:
  - `o_queue_full`=1 and the fifth is dropped.
  - Wake entry 2, then issue it → full deasserts the next cycle.
- Dispatch C with rs2 tag 9 in the same cycle as CDB tag 9, data 0xBEEF → C is stored ready and issues the next cycle with rs2_data=0xBEEF.
- Hold `i_issue_ready`=0 with entries 1 and 3 ready:
  - The offer is stable for 5 cycles.
  - With `INT_IQ_AGE_SELECT_EN` the older entry is offered; without it, entry 1 is offered.
- Three valid entries, `i_flush` together with `i_dispatch_en` → empty next cycle and nothing written. Mid-run `i_rst_n` low → `o_issue_valid`=0 immediately.
